// File: rtl/tbus_arbiter.sv
// Round-robin arbiter sharing one trinity bus port between instruction fetch (m0)
// and memblock (m1). One outstanding transaction; grant held until operation_done.
module tbus_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int MASK_WIDTH     = 64,
  parameter int OPTYPE_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    m0_index_valid,
  output logic                    m0_index_ready,
  input  logic [ADDR_WIDTH-1:0]   m0_index,
  input  logic [DATA_WIDTH-1:0]   m0_write_data,
  input  logic [MASK_WIDTH-1:0]   m0_write_mask,
  input  logic [OPTYPE_WIDTH-1:0] m0_operation_type,
  output logic [DATA_WIDTH-1:0]   m0_read_data,
  output logic                    m0_operation_done,
  input  logic                    m1_index_valid,
  output logic                    m1_index_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_index,
  input  logic [DATA_WIDTH-1:0]   m1_write_data,
  input  logic [MASK_WIDTH-1:0]   m1_write_mask,
  input  logic [OPTYPE_WIDTH-1:0] m1_operation_type,
  output logic [DATA_WIDTH-1:0]   m1_read_data,
  output logic                    m1_operation_done,
  output logic                    s_index_valid,
  input  logic                    s_index_ready,
  output logic [ADDR_WIDTH-1:0]   s_index,
  output logic [DATA_WIDTH-1:0]   s_write_data,
  output logic [MASK_WIDTH-1:0]   s_write_mask,
  output logic [OPTYPE_WIDTH-1:0] s_operation_type,
  input  logic [DATA_WIDTH-1:0]   s_read_data,
  input  logic                    s_operation_done,
  output logic                    owner,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  state_t           state_reg, state_next;
  logic             owner_reg, owner_next;
  logic             last_grant_reg, last_grant_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             timeout_err_reg, timeout_err_next;

  logic in_req, in_wait, owner_valid, fire, route_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      owner_reg       <= 1'b0;
      last_grant_reg  <= 1'b1;
      wait_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_grant_reg  <= last_grant_next;
      wait_cnt_reg    <= wait_cnt_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign in_req      = (state_reg == REQ);
  assign in_wait     = (state_reg == WAIT);
  assign owner_valid = owner_reg ? m1_index_valid : m0_index_valid;
  assign fire        = in_req & owner_valid & s_index_ready;
  // done is only meaningful once the request has actually gone downstream
  assign route_done  = (in_wait | fire) & s_operation_done;

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_grant_next  = last_grant_reg;
    wait_cnt_next    = wait_cnt_reg;
    timeout_err_next = timeout_err_reg;
    case (state_reg)
      IDLE: begin
        if (m0_index_valid | m1_index_valid) begin
          owner_next      = (m0_index_valid & m1_index_valid) ? ~last_grant_reg : m1_index_valid;
          last_grant_next = owner_next;
          state_next      = REQ;
        end
      end
      REQ: begin
        if (!owner_valid) begin
          state_next = IDLE;
        end else if (s_index_ready) begin
          state_next    = s_operation_done ? IDLE : WAIT;
          wait_cnt_next = '0;
        end
      end
      WAIT: begin
        if (s_operation_done) begin
          state_next = IDLE;
        end else begin
          if (wait_cnt_reg >= CNT_LAST) timeout_err_next = 1'b1;
          if (wait_cnt_reg != CNT_MAX) wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_index_valid    = in_req & owner_valid;
  assign s_index          = in_req ? (owner_reg ? m1_index          : m0_index)          : '0;
  assign s_write_data     = in_req ? (owner_reg ? m1_write_data     : m0_write_data)     : '0;
  assign s_write_mask     = in_req ? (owner_reg ? m1_write_mask     : m0_write_mask)     : '0;
  assign s_operation_type = in_req ? (owner_reg ? m1_operation_type : m0_operation_type) : '0;

  assign m0_index_ready    = in_req & ~owner_reg & s_index_ready;
  assign m1_index_ready    = in_req &  owner_reg & s_index_ready;
  assign m0_operation_done = route_done & ~owner_reg;
  assign m1_operation_done = route_done &  owner_reg;
  assign m0_read_data      = m0_operation_done ? s_read_data : '0;
  assign m1_read_data      = m1_operation_done ? s_read_data : '0;

  assign owner       = owner_reg;
  assign busy        = (state_reg != IDLE);
  assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_tbus_arbiter.sv
// Self-checking bench for tbus_arbiter: table of single-requester transactions plus
// hand-written contention, withdraw, timeout and reset sequences; done routing via scoreboard.
module tb_tbus_arbiter;

  localparam int AW = 64, DW = 64, MW = 64, OW = 2, TO = 8;
  localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1;

  logic clock = 1'b0, reset_n = 1'b0;
  logic m0_index_valid, m0_index_ready, m0_operation_done;
  logic m1_index_valid, m1_index_ready, m1_operation_done;
  logic [AW-1:0] m0_index, m1_index, s_index;
  logic [DW-1:0] m0_write_data, m1_write_data, s_write_data;
  logic [MW-1:0] m0_write_mask, m1_write_mask, s_write_mask;
  logic [OW-1:0] m0_operation_type, m1_operation_type, s_operation_type;
  logic [DW-1:0] m0_read_data, m1_read_data, s_read_data;
  logic s_index_valid, s_index_ready, s_operation_done;
  logic owner, busy, timeout_err;

  always #5 clock = ~clock;

  tbus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW),
                 .OPTYPE_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_index_valid(m0_index_valid), .m0_index_ready(m0_index_ready), .m0_index(m0_index),
    .m0_write_data(m0_write_data), .m0_write_mask(m0_write_mask),
    .m0_operation_type(m0_operation_type), .m0_read_data(m0_read_data),
    .m0_operation_done(m0_operation_done),
    .m1_index_valid(m1_index_valid), .m1_index_ready(m1_index_ready), .m1_index(m1_index),
    .m1_write_data(m1_write_data), .m1_write_mask(m1_write_mask),
    .m1_operation_type(m1_operation_type), .m1_read_data(m1_read_data),
    .m1_operation_done(m1_operation_done),
    .s_index_valid(s_index_valid), .s_index_ready(s_index_ready), .s_index(s_index),
    .s_write_data(s_write_data), .s_write_mask(s_write_mask),
    .s_operation_type(s_operation_type), .s_read_data(s_read_data),
    .s_operation_done(s_operation_done),
    .owner(owner), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    bit          req;
    logic [1:0]  op;
    logic [63:0] idx;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [63:0] rdata;
    int          ready_wait;
    int          done_lat;
  } vec_t;

  typedef struct {
    bit          who;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every observed done must match the oldest expected response.
  task automatic sb_check();
    exp_t e;
    if (m0_operation_done === 1'b1 || m1_operation_done === 1'b1) begin
      chk("done_both", {63'd0, m0_operation_done & m1_operation_done}, 64'd0);
      if (sb_q.size() == 0) begin
        chk("done_unexpected", {63'd0, m1_operation_done}, 64'd2);
      end else begin
        e = sb_q.pop_front();
        chk("done_owner", {63'd0, m1_operation_done}, {63'd0, e.who});
        chk("done_rdata", m1_operation_done ? m1_read_data : m0_read_data, e.data);
        chk("done_other_rdata", m1_operation_done ? m0_read_data : m1_read_data, 64'd0);
      end
    end
  endtask

  task automatic push_exp(input bit who, input logic [63:0] data);
    exp_t e;
    e.who = who;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    @(negedge clock);
    sb_check();
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  function automatic logic rdy_of(input bit r);
    return r ? m1_index_ready : m0_index_ready;
  endfunction

  function automatic logic done_of(input bit r);
    return r ? m1_operation_done : m0_operation_done;
  endfunction

  task automatic set_req(input bit r, input logic v, input logic [63:0] idx,
                         input logic [63:0] wd, input logic [63:0] wm, input logic [1:0] op);
    if (r) begin
      m1_index_valid = v; m1_index = idx; m1_write_data = wd;
      m1_write_mask = wm; m1_operation_type = op;
    end else begin
      m0_index_valid = v; m0_index = idx; m0_write_data = wd;
      m0_write_mask = wm; m0_operation_type = op;
    end
  endtask

  task automatic clr_all();
    set_req(1'b0, 1'b0, 64'd0, 64'd0, 64'd0, OP_READ);
    set_req(1'b1, 1'b0, 64'd0, 64'd0, 64'd0, OP_READ);
    s_index_ready = 1'b0; s_operation_done = 1'b0; s_read_data = '0;
  endtask

  task automatic do_txn(input vec_t v);
    set_req(v.req, 1'b1, v.idx, v.wdata, v.wmask, v.op);
    s_index_ready = 1'b0;
    sample();
    chk("bubble_valid", {63'd0, s_index_valid}, 64'd0);
    advance();
    for (int w = 0; w < v.ready_wait; w++) begin
      sample();
      chk("bp_valid", {63'd0, s_index_valid}, 64'd1);
      chk("bp_index", s_index, v.idx);
      chk("bp_wdata", s_write_data, v.wdata);
      chk("bp_wmask", s_write_mask, v.wmask);
      chk("bp_op", {62'd0, s_operation_type}, {62'd0, v.op});
      chk("bp_owner", {63'd0, owner}, {63'd0, v.req});
      chk("bp_rdy_owner", {63'd0, rdy_of(v.req)}, 64'd0);
      chk("bp_rdy_other", {63'd0, rdy_of(!v.req)}, 64'd0);
      advance();
    end
    s_index_ready = 1'b1;
    if (v.done_lat == 0) begin
      s_operation_done = 1'b1; s_read_data = v.rdata;
      push_exp(v.req, v.rdata);
    end
    sample();
    chk("fire_valid", {63'd0, s_index_valid}, 64'd1);
    chk("fire_index", s_index, v.idx);
    chk("fire_rdy_owner", {63'd0, rdy_of(v.req)}, 64'd1);
    chk("fire_rdy_other", {63'd0, rdy_of(!v.req)}, 64'd0);
    chk("fire_done", {63'd0, done_of(v.req)}, {63'd0, v.done_lat == 0});
    advance();
    clr_all();
    if (v.done_lat > 0) begin
      for (int k = 1; k < v.done_lat; k++) begin
        sample();
        chk("wait_valid", {63'd0, s_index_valid}, 64'd0);
        chk("wait_done", {63'd0, done_of(v.req)}, 64'd0);
        chk("wait_busy", {63'd0, busy}, 64'd1);
        advance();
      end
      s_operation_done = 1'b1; s_read_data = v.rdata;
      push_exp(v.req, v.rdata);
      sample();
      chk("resp_done", {63'd0, done_of(v.req)}, 64'd1);
      chk("resp_other_done", {63'd0, done_of(!v.req)}, 64'd0);
      advance();
      clr_all();
    end
    sample();
    chk("idle_busy", {63'd0, busy}, 64'd0);
    $display("txn req=m%0d idx=%0h rdata=%0h ready_wait=%0d done_lat=%0d",
             v.req, v.idx, v.rdata, v.ready_wait, v.done_lat);
    advance();
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, OP_READ,  64'h8000_1000, 64'd0, 64'd0, 64'hDEAD_BEEF, 0, 3};
    vecs[1] = '{1'b0, OP_WRITE, 64'h2000, 64'h1122_3344_5566_7788, 64'hFF, 64'd0, 5, 2};
    vecs[2] = '{1'b1, OP_READ,  64'h3000, 64'd0, 64'd0, 64'hCAFE_F00D, 0, 0};
    vecs[3] = '{1'b0, OP_READ,  64'h4000, 64'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 2, 0};
    vecs[4] = '{1'b1, OP_WRITE, 64'h5000, 64'hA5A5, 64'h0F, 64'h77, 1, 1};

    clr_all();
    sample();
    chk("rst_ctrl", {56'd0, s_index_valid, m0_index_ready, m1_index_ready, m0_operation_done,
                     m1_operation_done, owner, busy, timeout_err}, 64'd0);
    chk("rst_index", s_index, 64'd0);
    chk("rst_rdata", m0_read_data | m1_read_data, 64'd0);
    advance();
    reset_n = 1'b1;

    // Contention from reset: m0 first, then strict alternation.
    set_req(1'b0, 1'b1, 64'hA000, 64'd0, 64'd0, OP_READ);
    set_req(1'b1, 1'b1, 64'hB000, 64'd0, 64'd0, OP_READ);
    s_index_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bit exp_o;
      exp_o = bit'(i % 2);
      sample();
      chk("rr_bubble", {63'd0, s_index_valid}, 64'd0);
      advance();
      sample();
      chk("rr_owner", {63'd0, owner}, {63'd0, exp_o});
      chk("rr_index", s_index, exp_o ? 64'hB000 : 64'hA000);
      chk("rr_rdy_other", {63'd0, rdy_of(!exp_o)}, 64'd0);
      advance();
      s_operation_done = 1'b1; s_read_data = 64'h100 + 64'(i);
      push_exp(exp_o, 64'h100 + 64'(i));
      sample();
      chk("rr_done", {63'd0, done_of(exp_o)}, 64'd1);
      $display("txn contention #%0d owner=m%0d", i, owner);
      advance();
      s_operation_done = 1'b0; s_read_data = '0;
    end
    clr_all();
    sample();
    advance();

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // Withdraw: m1 drops valid in REQ while m0 is waiting.
    set_req(1'b1, 1'b1, 64'hC000, 64'd0, 64'd0, OP_READ);
    sample();
    advance();
    sample();
    chk("wd_owner", {63'd0, owner}, 64'd1);
    chk("wd_valid_before", {63'd0, s_index_valid}, 64'd1);
    advance();
    set_req(1'b1, 1'b0, 64'd0, 64'd0, 64'd0, OP_READ);
    set_req(1'b0, 1'b1, 64'hD000, 64'd0, 64'd0, OP_READ);
    sample();
    chk("wd_valid_drop", {63'd0, s_index_valid}, 64'd0);
    chk("wd_m0_rdy", {63'd0, m0_index_ready}, 64'd0);
    advance();
    sample();
    chk("wd_idle", {63'd0, busy}, 64'd0);
    chk("wd_idle_valid", {63'd0, s_index_valid}, 64'd0);
    advance();
    s_index_ready = 1'b1; s_operation_done = 1'b1; s_read_data = 64'h55;
    push_exp(1'b0, 64'h55);
    sample();
    chk("wd_m0_owner", {63'd0, owner}, 64'd0);
    chk("wd_m0_index", s_index, 64'hD000);
    chk("wd_m0_done", {63'd0, m0_operation_done}, 64'd1);
    $display("txn withdraw m1, then m0 idx=%0h", s_index);
    advance();
    clr_all();

    // Timeout: done withheld for TO wait cycles.
    set_req(1'b0, 1'b1, 64'h6000, 64'd0, 64'd0, OP_READ);
    s_index_ready = 1'b1;
    sample();
    advance();
    sample();
    chk("to_fire", {63'd0, m0_index_ready}, 64'd1);
    advance();
    clr_all();
    for (int k = 1; k <= TO; k++) begin
      sample();
      chk("to_pending", {63'd0, timeout_err}, 64'd0);
      chk("to_busy", {63'd0, busy}, 64'd1);
      advance();
    end
    s_operation_done = 1'b1; s_read_data = 64'h66;
    push_exp(1'b0, 64'h66);
    sample();
    chk("to_set", {63'd0, timeout_err}, 64'd1);
    chk("to_late_done", {63'd0, m0_operation_done}, 64'd1);
    $display("txn timeout m0 idx=6000 timeout_err=%0b", timeout_err);
    advance();
    clr_all();
    sample();
    chk("to_sticky", {63'd0, timeout_err}, 64'd1);
    chk("to_idle", {63'd0, busy}, 64'd0);
    advance();

    // Stray done in IDLE is forwarded to nobody.
    s_operation_done = 1'b1; s_read_data = 64'hBAD;
    sample();
    chk("stray_done", {62'd0, m1_operation_done, m0_operation_done}, 64'd0);
    chk("stray_rdata", m0_read_data | m1_read_data, 64'd0);
    advance();
    clr_all();

    // Reset in the middle of a WAIT phase.
    set_req(1'b1, 1'b1, 64'hE000, 64'd0, 64'd0, OP_READ);
    s_index_ready = 1'b1;
    sample();
    advance();
    sample();
    advance();
    clr_all();
    sample();
    chk("rw_busy", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    s_operation_done = 1'b1; s_read_data = 64'h99;
    #1;
    chk("rw_ctrl", {57'd0, s_index_valid, m0_index_ready, m1_index_ready, m0_operation_done,
                    m1_operation_done, busy, timeout_err}, 64'd0);
    chk("rw_rdata", m0_read_data | m1_read_data, 64'd0);
    $display("txn reset mid-wait busy=%0b timeout_err=%0b", busy, timeout_err);
    advance();
    reset_n = 1'b1;
    sample();
    chk("rw_done_ignored", {62'd0, m1_operation_done, m0_operation_done}, 64'd0);
    advance();
    clr_all();

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbus_arbiter.md
Name: tbus_arbiter

Overview:
- Two-requester arbiter that shares the single trinity bus (tbus) port to the memory/dcache side.
- Requester 0 is the instruction-fetch port; requester 1 is the memblock load/store port.
- Grants one requester at a time and holds the grant until that transaction's operation_done returns.
- Routes read data and done back to the owner only; fairness is round-robin.

Parameters:
- ADDR_WIDTH, 64, width of tbus_index.
- DATA_WIDTH, 64, width of write_data and read_data.
- MASK_WIDTH, 64, width of write_mask.
- OPTYPE_WIDTH, 2, width of operation_type.
- TIMEOUT_CYCLES, 1024, number of WAIT cycles without done before timeout_err is raised.

Ports:
- clock  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- m0_index_valid  in  1  fetch request valid
- m0_index_ready  out  1  fetch request accepted
- m0_index  in  ADDR_WIDTH  fetch address
- m0_write_data  in  DATA_WIDTH  fetch write data
- m0_write_mask  in  MASK_WIDTH  fetch write mask
- m0_operation_type  in  OPTYPE_WIDTH  fetch op type (TBUS_READ/TBUS_WRITE)
- m0_read_data  out  DATA_WIDTH  fetch read data
- m0_operation_done  out  1  fetch completion
- m1_*  same eight signals as m0_*  memblock requester
- s_index_valid  out  1  downstream request valid
- s_index_ready  in  1  downstream accept
- s_index  out  ADDR_WIDTH  downstream address
- s_write_data  out  DATA_WIDTH  downstream write data
- s_write_mask  out  MASK_WIDTH  downstream write mask
- s_operation_type  out  OPTYPE_WIDTH  downstream op type
- s_read_data  in  DATA_WIDTH  downstream read data
- s_operation_done  in  1  downstream completion
- owner  out  1  current grant holder (0 = m0, 1 = m1); meaningful only when busy=1
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky: a WAIT phase exceeded TIMEOUT_CYCLES

Behaviour:
- Reset: asynchronous, active-low on reset_n; clock is clock.
  - State returns to IDLE; owner=0; last_grant=1, so m0 wins the first tie.
  - wait_cnt=0; timeout_err=0.
  - All s_* and m*_ outputs are 0.
  - Reset mid-transaction abandons it; a later s_operation_done arriving in IDLE is ignored.
- States:
  - IDLE: register the arbitration result.
    - If both valids are high, grant the requester != last_grant.
    - If only one valid is high, grant that one.
    - On any grant: owner<=winner, last_grant<=winner, go to REQ.
    - This costs a 1-cycle arbitration bubble: the earliest s_index_valid is the cycle after the request is first seen.
  - REQ:
    - s_index_valid/index/write_data/write_mask/operation_type are driven combinationally from the owner's inputs.
    - The owner's m*_index_ready = s_index_ready; the other requester sees ready=0.
    - Fire = s_index_valid & s_index_ready.
    - If fire & s_operation_done in the same cycle: forward done and go to IDLE.
    - Else if fire: go to WAIT and clear wait_cnt.
    - If the owner drops valid before fire (e.g. flushed): go to IDLE with no downstream transaction; last_grant is still updated.
  - WAIT:
    - All s_* request outputs are 0; both readies are 0.
    - wait_cnt increments each cycle and saturates at TIMEOUT_CYCLES.
    - When wait_cnt reaches TIMEOUT_CYCLES-1 without done, set timeout_err=1. It is cleared only by reset.
    - On s_operation_done: go to IDLE.
- Response routing:
  - The owner's m*_operation_done = s_operation_done, only in WAIT or on a fire cycle in REQ.
  - The owner's m*_read_data = s_read_data in the same cycle, otherwise 0.
  - The non-owner always sees done=0 and read_data=0.
  - s_operation_done in IDLE is ignored and forwarded to nobody.
- Requests are never issued downstream while in WAIT: one outstanding transaction maximum.
- A requester that asserts valid during another requester's transaction waits. It is granted in the IDLE cycle following done, subject to round-robin.
- Back-to-back from one requester with the other idle: that requester is granted again. Each transaction costs 1 IDLE cycle.

Test Plan:
1. Single read: reset, m1_index_valid=1, op=READ, idx=0x80001000, s_index_ready=1, done 3 cycles after fire, s_read_data=0xDEADBEEF → s_index_valid rises 1 cycle after m1 valid with s_index=0x80001000; m1_operation_done=1 with m1_read_data=0xDEADBEEF; m0 sees done=0; busy falls the next cycle.
2. Contention: m0 and m1 both valid from reset → m0 granted first; after its done, m1 granted; a third tie goes to m0 again (alternation verified over 6 transactions).
3. Backpressure: s_index_ready=0 for 5 cycles in REQ → s_* fields stay stable and equal to the owner's; fire on cycle 6; the non-owner's ready stays 0 throughout.
4. Fire with same-cycle done: s_index_ready=1 and s_operation_done=1 on the fire cycle → owner done pulses that cycle; state goes to IDLE, WAIT is never entered.
5. Withdraw: m1 valid dropped in REQ before ready → no s_index_valid next cycle; state goes to IDLE; a pending m0 request is granted next.
6. Timeout and stray done: TIMEOUT_CYCLES=8, done withheld → timeout_err=1 after 8 WAIT cycles and stays 1 after a later done. A done pulse in IDLE produces no m*_operation_done. Assert reset_n=0 mid-WAIT → all outputs 0 immediately.
